// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and multiplier FSM state encoding.
// Latency: none, constants only.
// Backpressure: not applicable.
package alu_pkg;

    // Width of the ALU adder. Everything on the multiply path is built around it.
    localparam int ALU_WIDTH = 32;

    // Multiplier FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_multiplier_adder.sv
// ALU ripple adder: WIDTH-bit sum with carry-in and carry-out.
// Latency: purely combinational.
// Backpressure: none, no state.
module seq_multiplier_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout
);

    // Carry-out is kept as the extra top bit of the widened sum.
    assign {o_cout, o_result} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier producing a full 2*WIDTH product.
// Latency: o_valid rises WIDTH edges after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: o_ready high only in IDLE; o_valid/o_product held in DONE until i_ready.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product
);

    // The multiplier reuses the ALU adder, so its width is pinned to the adder's.
    generate
        if (WIDTH != ALU_WIDTH) begin : g_bad_width
            $error("seq_multiplier: WIDTH must equal ALU_WIDTH (32)");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_last;

    // Gating the addend with the multiplier LSB means a zero bit simply adds
    // nothing, so no separate bypass path around the adder is needed.
    assign w_addend = r_mcand & {WIDTH{r_lo[0]}};
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    assign o_ready   = (r_state == ST_IDLE);
    assign o_valid   = r_valid;
    assign o_product = r_product;

    seq_multiplier_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .i_a     (r_hi),
        .i_b     (w_addend),
        .i_cin   (1'b0),
        .o_result(w_sum),
        .o_cout  (w_cout)
    );

    // FSM: capture operands, run WIDTH add/shift steps, then hold the product until consumed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_mcand <= i_a;
                        r_lo    <= i_b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // {carry, sum, lo} shifted right by one: the carry becomes the
                    // new hi MSB and the sum LSB drops into the top of lo.
                    r_hi <= {w_cout, w_sum[WIDTH-1:1]};
                    r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                    if (w_last) begin
                        // Counter parks at WIDTH-1 so DONE fires exactly once;
                        // it is cleared again only by the next acceptance.
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_product <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
